// File: rtl/mbist_march_ctrl_if.sv
// Bus between the March C- BIST controller and the memory/test harness:
// memory strobes, address/data and run status.
interface mbist_march_ctrl_if #(
    parameter int unsigned length = 10,
    parameter int unsigned width  = 8
);
    logic              start;
    logic [width-1:0]  mem_rdata;
    logic              mem_re;
    logic              mem_we;
    logic [length-1:0] mem_addr;
    logic [width-1:0]  mem_wdata;
    logic              busy;
    logic              done;
    logic              fail;
    logic [length-1:0] fail_addr;

    modport master (
        input  start, mem_rdata,
        output mem_re, mem_we, mem_addr, mem_wdata, busy, done, fail, fail_addr
    );

    modport slave (
        output start, mem_rdata,
        input  mem_re, mem_we, mem_addr, mem_wdata, busy, done, fail, fail_addr
    );
endinterface

// File: rtl/mbist_march_ctrl.sv
// March C- memory BIST controller: runs the six march elements over a
// 2^length-word memory and records the address of the first bad read.
module mbist_march_ctrl #(
    parameter int unsigned length = 10,
    parameter int unsigned width  = 8
) (
    input  logic               clk,
    input  logic               rst,
    mbist_march_ctrl_if.master bus
);
    localparam int unsigned ELEM_W = 3;
    localparam logic [length-1:0] ADDR_LAST    = '1;
    localparam logic [ELEM_W-1:0] ELEM_LAST_UP = ELEM_W'(2);
    localparam logic [ELEM_W-1:0] ELEM_LAST    = ELEM_W'(5);

    typedef enum logic [2:0] {IDLE, RD, WR, FLUSH, DONE} state_e;

    state_e              state_q, state_d;
    logic [ELEM_W-1:0]   elem_q, elem_d;
    logic [length-1:0]   addr_q, addr_d;
    logic                re_q, re_d;
    logic                we_q, we_d;
    logic [width-1:0]    wdata_q, wdata_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                fail_q, fail_d;
    logic [length-1:0]   fail_addr_q, fail_addr_d;
    logic                rd_pend_q, rd_pend_d;
    logic [width-1:0]    rd_exp_q, rd_exp_d;
    logic [length-1:0]   rd_addr_q, rd_addr_d;

    logic                elem_up;
    logic [ELEM_W-1:0]   elem_nxt;
    logic                addr_term;
    logic [length-1:0]   addr_step;

    // State register and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            elem_q      <= '0;
            addr_q      <= '0;
            re_q        <= 1'b0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            rd_pend_q   <= 1'b0;
            rd_exp_q    <= '0;
            rd_addr_q   <= '0;
        end else begin
            state_q     <= state_d;
            elem_q      <= elem_d;
            addr_q      <= addr_d;
            re_q        <= re_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            fail_q      <= fail_d;
            fail_addr_q <= fail_addr_d;
            rd_pend_q   <= rd_pend_d;
            rd_exp_q    <= rd_exp_d;
            rd_addr_q   <= rd_addr_d;
        end
    end

    // Next state, march sequencing and read-compare pipeline
    always_comb begin
        state_d     = state_q;
        elem_d      = elem_q;
        addr_d      = addr_q;
        done_d      = done_q;
        fail_d      = fail_q;
        fail_addr_d = fail_addr_q;

        elem_up   = (elem_q <= ELEM_LAST_UP);
        elem_nxt  = ELEM_W'(elem_q + ELEM_W'(1));
        addr_term = elem_up ? (addr_q == ADDR_LAST) : (addr_q == '0);
        addr_step = elem_up ? length'(addr_q + 1'b1) : length'(addr_q - 1'b1);

        // Remember what the read issued this cycle must return next cycle
        rd_pend_d = (state_q == RD);
        rd_exp_d  = {width{(elem_q == ELEM_W'(2)) || (elem_q == ELEM_W'(4))}};
        rd_addr_d = addr_q;

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d     = WR;
                    elem_d      = '0;
                    addr_d      = '0;
                    done_d      = 1'b0;
                    fail_d      = 1'b0;
                    fail_addr_d = '0;
                end
            end
            WR: begin
                if (addr_term) begin
                    elem_d  = elem_nxt;
                    addr_d  = (elem_nxt <= ELEM_LAST_UP) ? '0 : ADDR_LAST;
                    state_d = RD;
                end else begin
                    addr_d  = addr_step;
                    state_d = (elem_q == '0) ? WR : RD;
                end
            end
            RD: begin
                if (elem_q != ELEM_LAST) begin
                    state_d = WR;
                end else if (addr_term) begin
                    state_d = FLUSH;
                    addr_d  = '0;
                end else begin
                    addr_d  = addr_step;
                end
            end
            FLUSH: begin
                state_d = DONE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        re_d    = (state_d == RD);
        we_d    = (state_d == WR);
        busy_d  = (state_d == RD) || (state_d == WR) || (state_d == FLUSH);
        wdata_d = {width{(state_d == WR) &&
                         ((elem_d == ELEM_W'(1)) || (elem_d == ELEM_W'(3)))}};

        // Only the first mismatch of a run is recorded
        if (rd_pend_q && (bus.mem_rdata != rd_exp_q) && !fail_q) begin
            fail_d      = 1'b1;
            fail_addr_d = rd_addr_q;
        end
    end

    assign bus.mem_re    = re_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.fail      = fail_q;
    assign bus.fail_addr = fail_addr_q;
endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Self-checking bench for mbist_march_ctrl: fault-injecting memory models,
// a fault table, randomized read corruption and multi-cycle corner cases.
module tb_mbist_march_ctrl;
    localparam int L0   = 2;
    localparam int L1   = 1;
    localparam int W    = 8;
    localparam int N0   = 4;
    localparam int N1   = 2;
    localparam int NRD0 = 5 * N0;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mbist_march_ctrl_if #(.length(L0), .width(W)) if0 ();
    mbist_march_ctrl_if #(.length(L1), .width(W)) if1 ();

    mbist_march_ctrl #(.length(L0), .width(W)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    mbist_march_ctrl #(.length(L1), .width(W)) dut1 (.clk(clk), .rst(rst), .bus(if1));

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Memory model for dut0: optional stuck-at cell plus per-read xor corruption
    logic [W-1:0] mem0 [N0];
    logic [W-1:0] mem1 [N1];
    logic [W-1:0] crpt [NRD0];
    int           rd_cnt0 = 0;
    bit           st_en;
    int           st_addr;
    int           st_bit;
    bit           st_val;

    function automatic logic [W-1:0] cell0(input logic [W-1:0] d, input int a);
        logic [W-1:0] r;
        r = d;
        if (st_en && a == st_addr) r[st_bit] = st_val;
        return r;
    endfunction

    always @(posedge clk) begin
        if (if0.mem_we) mem0[if0.mem_addr] <= cell0(if0.mem_wdata, int'(if0.mem_addr));
        if (if0.mem_re) begin
            if0.mem_rdata <= cell0(mem0[if0.mem_addr], int'(if0.mem_addr)) ^
                             ((rd_cnt0 < NRD0) ? crpt[rd_cnt0] : '0);
            rd_cnt0 <= rd_cnt0 + 1;
        end else if (if0.start && !if0.busy) begin
            rd_cnt0 <= 0;
        end
    end

    always @(posedge clk) begin
        if (if1.mem_we) mem1[if1.mem_addr] <= if1.mem_wdata;
        if (if1.mem_re) if1.mem_rdata <= mem1[if1.mem_addr];
    end

    // Reference: the March C- operation list built from the element table
    typedef struct { bit re; int addr; logic [W-1:0] data; } op_t;

    function automatic void build_ops(input int n, output op_t q[$]);
        op_t o;
        q = {};
        for (int e = 0; e < 6; e++) begin
            for (int i = 0; i < n; i++) begin
                o.addr = (e <= 2) ? i : n - 1 - i;
                if (e > 0) begin
                    o.re   = 1'b1;
                    o.data = (e == 2 || e == 4) ? {W{1'b1}} : {W{1'b0}};
                    q.push_back(o);
                end
                if (e < 5) begin
                    o.re   = 1'b0;
                    o.data = (e == 1 || e == 3) ? {W{1'b1}} : {W{1'b0}};
                    q.push_back(o);
                end
            end
        end
    endfunction

    // Start a run on dut0 (called at a negedge) and follow it to DONE
    task automatic run0(input bit hold, input bit noise, output int bc);
        op_t exp_q[$];
        int  k;
        int  errs;
        bit  fin;
        build_ops(N0, exp_q);
        bc = 0; k = 0; errs = 0; fin = 1'b0;
        if0.start = 1'b1;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (if0.done) begin
                fin = 1'b1;
                break;
            end
            if (if0.busy) bc++;
            if (if0.mem_re || if0.mem_we) begin
                if (k >= exp_q.size()) errs++;
                else if ((if0.mem_re && if0.mem_we) || (if0.mem_re != exp_q[k].re) ||
                         (int'(if0.mem_addr) != exp_q[k].addr) ||
                         (if0.mem_we && if0.mem_wdata != exp_q[k].data)) errs++;
                k++;
            end
            if (!hold) if0.start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        if (!hold) if0.start = 1'b0;
        check("run_reached_done", fin, 1);
        check("run_op_order_errors", errs, 0);
        check("run_op_count", k, 10 * N0);
    endtask

    task automatic check_end(input string tag, input int bc, input bit ef, input int ea);
        check({tag, "_busy_cycles"}, bc, 10 * N0 + 1);
        check({tag, "_fail"}, if0.fail, ef);
        check({tag, "_fail_addr"}, if0.fail_addr, ea);
        check({tag, "_idle_bus"}, {if0.mem_re, if0.mem_we, if0.mem_addr, if0.mem_wdata}, 0);
    endtask

    typedef struct {
        bit st_en; int st_addr; int st_bit; bit st_val;
        int ca; int cb; bit ef; int ea;
    } vec_t;

    vec_t vecs [6];
    op_t  ops [$];
    int   bc;
    int   rdx;
    bit   ef;
    int   ea;

    initial begin
        // st_en st_addr st_bit st_val | corrupt reads a,b | exp fail, addr
        vecs[0] = '{1'b1, 2, 0, 1'b0, -1, -1, 1'b1, 2};
        vecs[1] = '{1'b0, 0, 0, 1'b0, -1, -1, 1'b0, 0};
        vecs[2] = '{1'b0, 0, 0, 1'b0, 19, -1, 1'b1, 0};
        vecs[3] = '{1'b1, 3, 7, 1'b1, -1, -1, 1'b1, 3};
        vecs[4] = '{1'b1, 1, 3, 1'b0, -1, -1, 1'b1, 1};
        vecs[5] = '{1'b0, 0, 0, 1'b0, 10, 16, 1'b1, 1};

        rst = 1'b1;
        if0.start = 1'b0;
        if1.start = 1'b0;
        st_en = 1'b0; st_addr = 0; st_bit = 0; st_val = 1'b0;
        foreach (crpt[i]) crpt[i] = '0;
        repeat (3) @(negedge clk);
        check("reset_dut0_outputs", {if0.mem_re, if0.mem_we, if0.mem_addr, if0.mem_wdata,
              if0.busy, if0.done, if0.fail, if0.fail_addr}, 0);
        check("reset_dut1_outputs", {if1.mem_re, if1.mem_we, if1.mem_addr, if1.mem_wdata,
              if1.busy, if1.done, if1.fail, if1.fail_addr}, 0);
        rst = 1'b0;
        @(negedge clk);

        // Directed fault table
        foreach (vecs[v]) begin
            st_en = vecs[v].st_en; st_addr = vecs[v].st_addr;
            st_bit = vecs[v].st_bit; st_val = vecs[v].st_val;
            foreach (crpt[i]) crpt[i] = '0;
            if (vecs[v].ca >= 0) crpt[vecs[v].ca] = 8'h01;
            if (vecs[v].cb >= 0) crpt[vecs[v].cb] = 8'h80;
            run0(1'b0, 1'b0, bc);
            check_end($sformatf("vec%0d", v), bc, vecs[v].ef, vecs[v].ea);
        end

        // Randomized read corruption with start noise while busy
        st_en = 1'b0;
        build_ops(N0, ops);
        for (int t = 0; t < 12; t++) begin
            foreach (crpt[i]) crpt[i] = ($urandom_range(0, 9) == 0) ? W'($urandom_range(1, 255)) : '0;
            rdx = 0; ef = 1'b0; ea = 0;
            foreach (ops[j]) begin
                if (ops[j].re) begin
                    if (!ef && crpt[rdx] != '0) begin
                        ef = 1'b1;
                        ea = ops[j].addr;
                    end
                    rdx++;
                end
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run0(1'b0, 1'b1, bc);
            check_end($sformatf("rand%0d", t), bc, ef, ea);
        end
        foreach (crpt[i]) crpt[i] = '0;

        // Reset in the middle of M3 after a failure has been flagged
        st_en = 1'b1; st_addr = 3; st_bit = 7; st_val = 1'b1;
        if0.start = 1'b1;
        @(negedge clk);
        if0.start = 1'b0;
        repeat (22) @(negedge clk);
        check("midrst_fail_before", if0.fail, 1);
        check("midrst_in_m3_busy", if0.busy, 1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_outputs_zero", {if0.mem_re, if0.mem_we, if0.mem_addr, if0.mem_wdata,
              if0.busy, if0.done, if0.fail, if0.fail_addr}, 0);
        rst = 1'b0;
        st_en = 1'b0;
        @(negedge clk);
        run0(1'b0, 1'b0, bc);
        check_end("after_midrst", bc, 1'b0, 0);

        // start held high: no restart while busy, restart from DONE clears flags
        st_en = 1'b1; st_addr = 2; st_bit = 0; st_val = 1'b0;
        run0(1'b1, 1'b0, bc);
        check_end("hold", bc, 1'b1, 2);
        @(negedge clk);
        check("hold_restart_done", if0.done, 0);
        check("hold_restart_busy", if0.busy, 1);
        check("hold_restart_fail", if0.fail, 0);
        check("hold_restart_fail_addr", if0.fail_addr, 0);
        if0.start = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        st_en = 1'b0;
        @(negedge clk);

        // length=1 boundary on dut1
        begin
            int  k1;
            int  e1;
            int  b1;
            bit  f1;
            build_ops(N1, ops);
            k1 = 0; e1 = 0; b1 = 0; f1 = 1'b0;
            if1.start = 1'b1;
            for (int c = 0; c < 100; c++) begin
                @(negedge clk);
                if1.start = 1'b0;
                if (if1.done) begin
                    f1 = 1'b1;
                    break;
                end
                if (if1.busy) b1++;
                if (if1.mem_re || if1.mem_we) begin
                    if (k1 >= ops.size()) e1++;
                    else if ((if1.mem_re && if1.mem_we) || (if1.mem_re != ops[k1].re) ||
                             (int'(if1.mem_addr) != ops[k1].addr) ||
                             (if1.mem_we && if1.mem_wdata != ops[k1].data)) e1++;
                    k1++;
                end
            end
            check("len1_done", f1, 1);
            check("len1_busy_cycles", b1, 10 * N1 + 1);
            check("len1_op_order_errors", e1, 0);
            check("len1_op_count", k1, 10 * N1);
            check("len1_fail", if1.fail, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
